// File: rtl/lockin_pkg.sv
// Shared types and width helpers for the lock-in multichannel controller.
// Used by lockin_ch_sel and lockin_mc_controller.
package lockin_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_CH   = 3'd1,
      S_FETCH     = 3'd2,
      S_WAIT_DATA = 3'd3,
      S_MIX_START = 3'd4,
      S_WAIT_MIX  = 3'd5,
      S_OUTPUT    = 3'd6,
      S_NEXT      = 3'd7
   } state_t;

   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int addr_w(input int d);
      return $clog2(d);
   endfunction

endpackage

// File: rtl/lockin_ch_sel.sv
// Priority encoder: lowest enabled channel, either from index 0 (first=1)
// or strictly above cur (first=0).
module lockin_ch_sel
   import lockin_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CW     = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CW-1:0]     cur,
   input  logic              first,
   output logic [CW-1:0]     idx,
   output logic              found
);

   // Descending scan so the lowest qualifying index wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (mask[k] && (first || (k > int'(cur)))) begin
            idx   = CW'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lockin_mc_controller.sv
// Multichannel lock-in sequencer: buffer -> DDFS -> mixer -> CIC per channel.
// Optional watchdog on DDFS/mixer waits: define LOCKIN_MC_TIMEOUT_EN.
module lockin_mc_controller
   import lockin_pkg::*;
#(
   parameter int BUFFER_DEPTH       = 512,
   parameter int DATA_WIDTH         = 24,
   parameter int FREQUENCY_SIZE_IN  = 13,
   parameter int FREQUENCY_SIZE_OUT = 16,
   parameter int SIN_WIDTH          = 18,
   parameter int NUM_CH             = 4,
   localparam int CW  = ch_w(NUM_CH),
   localparam int AW  = addr_w(BUFFER_DEPTH),
   localparam int MW  = DATA_WIDTH + SIN_WIDTH,
   localparam int FSI = FREQUENCY_SIZE_IN,
   localparam int FSO = FREQUENCY_SIZE_OUT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_CH*FSI-1:0] tuning_words_in,
   input  logic [NUM_CH-1:0]     ch_en_in,
   input  logic                  buffer_ready,
   output logic [AW-1:0]         buffer_addr,
   input  logic [DATA_WIDTH-1:0] buffer_data,
   output logic                  buffer_release,
   output logic [FSO-1:0]        ddfs_tuning_word,
   output logic                  ddfs_phase_clr,
   output logic                  ddfs_sample_en,
   input  logic                  ddfs_valid_out,
   input  logic [SIN_WIDTH-1:0]  ddfs_sine_out,
   input  logic [SIN_WIDTH-1:0]  ddfs_cosine_out,
   output logic                  mixer_start_en,
   output logic [DATA_WIDTH-1:0] mixer_data_in,
   output logic [SIN_WIDTH-1:0]  mixer_sine_in,
   output logic [SIN_WIDTH-1:0]  mixer_cosine_in,
   input  logic [MW-1:0]         mixer_phase_out,
   input  logic [MW-1:0]         mixer_quadrature_out,
   input  logic                  mixer_valid_out,
   output logic [MW-1:0]         cic_phase_in,
   output logic [MW-1:0]         cic_quadrature_in,
   output logic [AW-1:0]         cic_addr_in,
   output logic [CW-1:0]         cic_ch_in,
   output logic                  cic_last_in,
   output logic                  cic_valid_in,
   input  logic                  cic_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   state_t state_q, state_d;

   logic [NUM_CH*FSI-1:0] sh_words;
   logic [NUM_CH-1:0]     sh_en;
   logic [CW-1:0]         ch;
   logic [AW-1:0]         cnt;
   logic                  br_q, done_q, rel_q, ovr_q;
   logic                  accept, empty, fin, abort;
   logic                  last, wd_hit;
   logic [NUM_CH-1:0]     sel_mask;
   logic                  sel_first;
   logic [CW-1:0]         sel_idx;
   logic                  sel_found;

   assign last      = (cnt == AW'(BUFFER_DEPTH - 1));
   assign sel_first = (state_q == S_IDLE);
   assign sel_mask  = sel_first ? ch_en_in : sh_en;

   lockin_ch_sel #(
      .NUM_CH (NUM_CH),
      .CW     (CW)
   ) u_ch_sel (
      .mask  (sel_mask),
      .cur   (ch),
      .first (sel_first),
      .idx   (sel_idx),
      .found (sel_found)
   );

`ifdef LOCKIN_MC_TIMEOUT_EN
   logic [15:0] wd_q;
   logic        waiting;

   assign waiting = (state_q == S_WAIT_DATA && !ddfs_valid_out) ||
                    (state_q == S_WAIT_MIX && !mixer_valid_out);
   // Fires on the 65535th consecutive cycle without a valid.
   assign wd_hit  = waiting && (wd_q == 16'hFFFE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_q <= '0;
      end else if (waiting && !wd_hit) begin
         wd_q <= wd_q + 16'd1;
      end else begin
         wd_q <= '0;
      end
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      empty   = 1'b0;
      fin     = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Ignore ready while the previous release pulse is out.
            if (buffer_ready && !rel_q) begin
               if (sel_found) begin
                  accept  = 1'b1;
                  state_d = S_LOAD_CH;
               end else begin
                  empty = 1'b1;
               end
            end
         end
         S_LOAD_CH:   state_d = S_FETCH;
         S_FETCH:     state_d = S_WAIT_DATA;
         S_WAIT_DATA: if (ddfs_valid_out) state_d = S_MIX_START;
         S_MIX_START: state_d = S_WAIT_MIX;
         S_WAIT_MIX:  if (mixer_valid_out) state_d = S_OUTPUT;
         S_OUTPUT:    if (cic_ready) state_d = S_NEXT;
         S_NEXT: begin
            if (!last) begin
               state_d = S_FETCH;
            end else if (sel_found) begin
               state_d = S_LOAD_CH;
            end else begin
               fin     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wd_hit) begin
         abort   = 1'b1;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_words          <= '0;
         sh_en             <= '0;
         ch                <= '0;
         cnt               <= '0;
         br_q              <= 1'b0;
         done_q            <= 1'b0;
         rel_q             <= 1'b0;
         ovr_q             <= 1'b0;
         mixer_data_in     <= '0;
         mixer_sine_in     <= '0;
         mixer_cosine_in   <= '0;
         cic_phase_in      <= '0;
         cic_quadrature_in <= '0;
         cic_addr_in       <= '0;
         cic_ch_in         <= '0;
         cic_last_in       <= 1'b0;
         cic_valid_in      <= 1'b0;
      end else begin
         br_q   <= buffer_ready;
         done_q <= empty | fin;
         rel_q  <= empty | fin | abort;
         if ((state_q != S_IDLE && buffer_ready && !br_q) || abort) begin
            ovr_q <= 1'b1;
         end
         if (accept) begin
            sh_words <= tuning_words_in;
            sh_en    <= ch_en_in;
            ch       <= sel_idx;
         end
         if (state_q == S_LOAD_CH) begin
            cnt <= '0;
         end
         if (state_q == S_NEXT) begin
            if (!last) begin
               cnt <= cnt + AW'(1);
            end else if (sel_found) begin
               ch <= sel_idx;
            end
         end
         // Address has been stable since FETCH, so buffer_data is valid here.
         if (state_q == S_WAIT_DATA && ddfs_valid_out) begin
            mixer_data_in   <= buffer_data;
            mixer_sine_in   <= ddfs_sine_out;
            mixer_cosine_in <= ddfs_cosine_out;
         end
         if (state_q == S_WAIT_MIX && mixer_valid_out) begin
            cic_phase_in      <= mixer_phase_out;
            cic_quadrature_in <= mixer_quadrature_out;
            cic_addr_in       <= cnt;
            cic_ch_in         <= ch;
            cic_last_in       <= last;
            cic_valid_in      <= 1'b1;
         end
         if (state_q == S_OUTPUT && cic_ready) begin
            cic_valid_in <= 1'b0;
         end
      end
   end

   assign busy             = (state_q != S_IDLE);
   assign ddfs_phase_clr   = (state_q == S_LOAD_CH);
   assign ddfs_sample_en   = (state_q == S_FETCH);
   assign mixer_start_en   = (state_q == S_MIX_START);
   assign buffer_addr      = cnt;
   assign frame_done       = done_q;
   assign buffer_release   = rel_q;
   assign overrun          = ovr_q;
   assign ddfs_tuning_word = FSO'(sh_words[int'(ch)*FSI +: FSI]);

endmodule

// File: tb/tb_lockin_mc_controller.sv
// Scoreboard bench for lockin_mc_controller with DDFS, mixer and buffer models.
// Two channels, eight-sample frames.
module tb_lockin_mc_controller;

   localparam int DEPTH = 8;
   localparam int NCH   = 2;
   localparam int DW    = 24;
   localparam int FSI   = 13;
   localparam int FSO   = 16;
   localparam int SW    = 18;
   localparam int MW    = DW + SW;
   localparam int AW    = 3;
   localparam int CW    = 1;

   logic               clk;
   logic               reset_n;
   logic [NCH*FSI-1:0] tuning_words_in;
   logic [NCH-1:0]     ch_en_in;
   logic               buffer_ready;
   logic [AW-1:0]      buffer_addr;
   logic [DW-1:0]      buffer_data;
   logic               buffer_release;
   logic [FSO-1:0]     ddfs_tuning_word;
   logic               ddfs_phase_clr;
   logic               ddfs_sample_en;
   logic               ddfs_valid_out;
   logic [SW-1:0]      ddfs_sine_out;
   logic [SW-1:0]      ddfs_cosine_out;
   logic               mixer_start_en;
   logic [DW-1:0]      mixer_data_in;
   logic [SW-1:0]      mixer_sine_in;
   logic [SW-1:0]      mixer_cosine_in;
   logic [MW-1:0]      mixer_phase_out;
   logic [MW-1:0]      mixer_quadrature_out;
   logic               mixer_valid_out;
   logic [MW-1:0]      cic_phase_in;
   logic [MW-1:0]      cic_quadrature_in;
   logic [AW-1:0]      cic_addr_in;
   logic [CW-1:0]      cic_ch_in;
   logic               cic_last_in;
   logic               cic_valid_in;
   logic               cic_ready;
   logic               busy;
   logic               frame_done;
   logic               overrun;

   lockin_mc_controller #(
      .BUFFER_DEPTH       (DEPTH),
      .DATA_WIDTH         (DW),
      .FREQUENCY_SIZE_IN  (FSI),
      .FREQUENCY_SIZE_OUT (FSO),
      .SIN_WIDTH          (SW),
      .NUM_CH             (NCH)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .tuning_words_in      (tuning_words_in),
      .ch_en_in             (ch_en_in),
      .buffer_ready         (buffer_ready),
      .buffer_addr          (buffer_addr),
      .buffer_data          (buffer_data),
      .buffer_release       (buffer_release),
      .ddfs_tuning_word     (ddfs_tuning_word),
      .ddfs_phase_clr       (ddfs_phase_clr),
      .ddfs_sample_en       (ddfs_sample_en),
      .ddfs_valid_out       (ddfs_valid_out),
      .ddfs_sine_out        (ddfs_sine_out),
      .ddfs_cosine_out      (ddfs_cosine_out),
      .mixer_start_en       (mixer_start_en),
      .mixer_data_in        (mixer_data_in),
      .mixer_sine_in        (mixer_sine_in),
      .mixer_cosine_in      (mixer_cosine_in),
      .mixer_phase_out      (mixer_phase_out),
      .mixer_quadrature_out (mixer_quadrature_out),
      .mixer_valid_out      (mixer_valid_out),
      .cic_phase_in         (cic_phase_in),
      .cic_quadrature_in    (cic_quadrature_in),
      .cic_addr_in          (cic_addr_in),
      .cic_ch_in            (cic_ch_in),
      .cic_last_in          (cic_last_in),
      .cic_valid_in         (cic_valid_in),
      .cic_ready            (cic_ready),
      .busy                 (busy),
      .frame_done           (frame_done),
      .overrun              (overrun)
   );

   typedef struct {
      int                    ch;
      int                    addr;
      logic                  last;
      logic signed [MW-1:0]  p;
      logic signed [MW-1:0]  q;
   } exp_t;

   exp_t                 sb[$];
   int                   tw_q[$];
   logic signed [DW-1:0] mem[DEPTH];

   int   n_cmp = 0;
   int   n_err = 0;
   int   xfer_cnt = 0;
   int   fd_cnt = 0;
   int   rel_cnt = 0;
   int   pclr_cnt = 0;
   int   dd_lat = 1;
   int   mix_lat = 1;
   int   bp_mode = 0;
   logic ovr_exp = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic signed [SW-1:0] sin_f(input logic [15:0] ph);
      return $signed({ph, 2'b01});
   endfunction

   function automatic logic signed [SW-1:0] cos_f(input logic [15:0] ph);
      return $signed({~ph, 2'b10});
   endfunction

   // Frame buffer: one-cycle read latency.
   always @(posedge clk) buffer_data <= mem[buffer_addr];

   // DDFS: phase accumulator, output dd_lat cycles after the sample strobe.
   logic [15:0]          ph;
   logic signed [SW-1:0] ds, dc;
   int                   dcnt;
   always @(posedge clk) begin
      ddfs_valid_out <= 1'b0;
      if (!reset_n) begin
         ph   <= '0;
         dcnt <= 0;
      end else begin
         if (ddfs_phase_clr) ph <= '0;
         if (ddfs_sample_en) begin
            ds   <= sin_f(ph);
            dc   <= cos_f(ph);
            ph   <= ph + ddfs_tuning_word;
            dcnt <= dd_lat;
         end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
               ddfs_valid_out  <= 1'b1;
               ddfs_sine_out   <= ds;
               ddfs_cosine_out <= dc;
            end
         end
      end
   end

   // Mixer: signed products, mix_lat cycles after start.
   logic signed [MW-1:0] mp, mq;
   int                   mcnt;
   always @(posedge clk) begin
      mixer_valid_out <= 1'b0;
      if (!reset_n) begin
         mcnt <= 0;
      end else if (mixer_start_en) begin
         mp   <= $signed(mixer_data_in) * $signed(mixer_sine_in);
         mq   <= $signed(mixer_data_in) * $signed(mixer_cosine_in);
         mcnt <= mix_lat;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) begin
            mixer_valid_out      <= 1'b1;
            mixer_phase_out      <= mp;
            mixer_quadrature_out <= mq;
         end
      end
   end

   // CIC backpressure, changed just after the rising edge.
   initial begin
      int bpc;
      bpc = 0;
      cic_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bpc++;
         case (bp_mode)
            0:       cic_ready = 1'b1;
            1:       cic_ready = (bpc % 6 == 5);
            default: cic_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: transfers, hold stability, pulse widths, tuning words.
   logic [4:0]           pp = '0;
   logic                 hold_q = 1'b0;
   logic signed [MW-1:0] hp, hq;
   logic [5:0]           hm;
   always @(negedge clk) begin
      logic [4:0] pv;
      exp_t       e;
      pv = {ddfs_phase_clr, ddfs_sample_en, mixer_start_en,
            frame_done, buffer_release};
      if (!reset_n) begin
         hold_q = 1'b0;
         pp     = '0;
      end else begin
         if (hold_q) begin
            chk("hold_phase", $signed(cic_phase_in), hp);
            chk("hold_quad", $signed(cic_quadrature_in), hq);
            chk("hold_ctl", {cic_addr_in, cic_ch_in, cic_last_in,
                             cic_valid_in}, hm);
         end
         if (cic_valid_in && cic_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_xfer", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("cic_ch", cic_ch_in, e.ch);
               chk("cic_addr", cic_addr_in, e.addr);
               chk("cic_last", cic_last_in, e.last);
               chk("cic_phase", $signed(cic_phase_in), e.p);
               chk("cic_quad", $signed(cic_quadrature_in), e.q);
            end
         end
         hold_q = cic_valid_in && !cic_ready;
         hp     = $signed(cic_phase_in);
         hq     = $signed(cic_quadrature_in);
         hm     = {cic_addr_in, cic_ch_in, cic_last_in, cic_valid_in};
         for (int i = 0; i < 5; i++) begin
            if (pv[i]) chk($sformatf("pulse%0d_width", i), pp[i], 0);
         end
         pp = pv;
         if (frame_done) fd_cnt++;
         if (buffer_release) rel_cnt++;
         if (ddfs_phase_clr) begin
            pclr_cnt++;
            if (tw_q.size() == 0) chk("tw_unexpected", 1, 0);
            else chk("tuning_word", ddfs_tuning_word, tw_q.pop_front());
         end
      end
   end

   task automatic push_frame(input logic [1:0] mask, input logic [12:0] w0,
                             input logic [12:0] w1);
      exp_t        e;
      logic [12:0] w;
      logic [15:0] pa;
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
      mem[DEPTH-1] = 24'sh800000;
      mem[0]       = 24'sh7FFFFF;
      for (int k = 0; k < NCH; k++) begin
         if (mask[k]) begin
            w = (k == 0) ? w0 : w1;
            tw_q.push_back(int'(w));
            for (int a = 0; a < DEPTH; a++) begin
               pa     = 16'(a * int'(w));
               e.ch   = k;
               e.addr = a;
               e.last = (a == DEPTH - 1);
               e.p    = mem[a] * sin_f(pa);
               e.q    = mem[a] * cos_f(pa);
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic run_frame(input logic [1:0] mask, input logic [12:0] w0,
                            input logic [12:0] w1, input bit do_ovr);
      int b_x, b_fd, b_rel, b_pc, nch;
      bit got;
      b_x   = xfer_cnt;
      b_fd  = fd_cnt;
      b_rel = rel_cnt;
      b_pc  = pclr_cnt;
      nch   = $countones(mask);
      push_frame(mask, w0, w1);
      @(negedge clk);
      tuning_words_in = {w1, w0};
      ch_en_in        = mask;
      buffer_ready    = 1'b1;
      @(negedge clk);
      tuning_words_in = NCH*FSI'($urandom);
      ch_en_in        = 2'($urandom);
      if (mask == 2'b00) begin
         chk("empty_done", frame_done, 1);
         chk("empty_release", buffer_release, 1);
      end else begin
         chk("busy_start", busy, 1);
      end
      if (do_ovr) begin
         repeat (4) @(negedge clk);
         buffer_ready = 1'b0;
         @(negedge clk);
         buffer_ready = 1'b1;
         ovr_exp      = 1'b1;
         @(negedge clk);
         chk("overrun_set", overrun, 1);
      end
      got = 1'b0;
      for (int i = 0; i < 4000 && !got; i++) begin
         if (buffer_release) got = 1'b1;
         else @(negedge clk);
      end
      chk("frame_end_seen", got, 1);
      buffer_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("xfers", xfer_cnt - b_x, nch * DEPTH);
      chk("frame_done_cnt", fd_cnt - b_fd, 1);
      chk("release_cnt", rel_cnt - b_rel, 1);
      chk("phase_clr_cnt", pclr_cnt - b_pc, nch);
      chk("sb_left", sb.size(), 0);
      chk("overrun", overrun, ovr_exp);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      int  b_x, b_fd, b_rel;
      bit  got;
      reset_n         = 1'b0;
      tuning_words_in = '0;
      ch_en_in        = '0;
      buffer_ready    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_release", buffer_release, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_cic_valid", cic_valid_in, 0);
      chk("rst_tw", ddfs_tuning_word, 0);
      chk("rst_addr", buffer_addr, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(2'b11, 13'd100, 13'd200, 1'b0);
      run_frame(2'b10, 13'd100, 13'd200, 1'b0);
      run_frame(2'b00, 13'd5, 13'd6, 1'b0);

      bp_mode = 1;
      dd_lat  = 2;
      mix_lat = 3;
      run_frame(2'b11, 13'h1FFF, 13'd1, 1'b0);
      bp_mode = 2;
      dd_lat  = 1;
      mix_lat = 2;
      run_frame(2'b01, 13'd4321, 13'd77, 1'b0);
      run_frame(2'b11, 13'd999, 13'd3000, 1'b1);

      // Abort mid-frame with reset.
      bp_mode = 0;
      b_x     = xfer_cnt;
      push_frame(2'b11, 13'd321, 13'd4095);
      @(negedge clk);
      tuning_words_in = {13'd4095, 13'd321};
      ch_en_in        = 2'b11;
      buffer_ready    = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         if (xfer_cnt - b_x >= 5) got = 1'b1;
         else @(negedge clk);
      end
      chk("midframe_reached", got, 1);
      b_fd         = fd_cnt;
      b_rel        = rel_cnt;
      reset_n      = 1'b0;
      buffer_ready = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_cic_valid", cic_valid_in, 0);
      chk("abort_overrun", overrun, 0);
      chk("abort_addr", buffer_addr, 0);
      chk("abort_tw", ddfs_tuning_word, 0);
      chk("abort_done", frame_done, 0);
      chk("abort_release", buffer_release, 0);
      chk("abort_cic_phase", cic_phase_in, 0);
      repeat (2) @(negedge clk);
      sb.delete();
      tw_q.delete();
      ovr_exp = 1'b0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_done", fd_cnt - b_fd, 0);
      chk("abort_no_release", rel_cnt - b_rel, 0);

      run_frame(2'b01, 13'd42, 13'd43, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
